// File: rtl/johnson_counter_param.sv
// johnson_counter_param: 2*WIDTH-phase Johnson counter with direction, load, phase decode, wrap and illegal-state flags
module johnson_counter_param #(
  parameter int WIDTH        = 8,
  parameter int RESET_PHASE  = 0,
  parameter int SELF_CORRECT = 1
) (
  input  logic                         Clk_In,
  input  logic                         Resetb_In,
  input  logic                         Start_Stopb_In,
  input  logic                         Dir_In,
  input  logic                         Load_In,
  input  logic [WIDTH-1:0]             Load_Value_In,
  output logic [WIDTH-1:0]             Count_Out,
  output logic [$clog2(2*WIDTH)-1:0]   Phase_Out,
  output logic                         Wrap_Out,
  output logic                         Illegal_Out
);
  localparam int PW = $clog2(2*WIDTH);
  function automatic logic [WIDTH-1:0] pattern(input int p);
    for (int i = 0; i < WIDTH; i++) pattern[i] = (p <= WIDTH) ? (i < p) : (i >= p - WIDTH);
  endfunction
  function automatic logic legal(input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] d;
    d = c ^ (c >> 1);
    d[WIDTH-1] = 1'b0;
    return (d & (d - 1'b1)) == '0;
  endfunction
  localparam logic [WIDTH-1:0] RST_PAT  = pattern(RESET_PHASE);
  localparam logic [WIDTH-1:0] LAST_PAT = pattern(2*WIDTH-1);
  localparam logic             SC       = SELF_CORRECT != 0;
  logic [WIDTH-1:0] step, nxt;
  logic             fix, ld_ill, wrap_n, ill_n;
  int               pop;
  always_comb begin
    step   = Dir_In ? {~Count_Out[0], Count_Out[WIDTH-1:1]} : {Count_Out[WIDTH-2:0], ~Count_Out[WIDTH-1]};
    ld_ill = !legal(Load_Value_In);
    fix    = SC && !legal(Count_Out);
    nxt    = Load_In ? ((ld_ill && SC) ? '0 : Load_Value_In) : fix ? '0 : Start_Stopb_In ? step : Count_Out;
    wrap_n = !Load_In && !fix && Start_Stopb_In && (Dir_In ? Count_Out == '0 : Count_Out == LAST_PAT);
    ill_n  = Load_In ? ld_ill : (fix || !legal(nxt));
  end
  // Legal patterns with the MSB set mirror the low half: phase = 2*WIDTH - popcount.
  always_comb begin
    pop = 0;
    for (int i = 0; i < WIDTH; i++) pop += int'(Count_Out[i]);
    Phase_Out = Count_Out[WIDTH-1] ? PW'(2*WIDTH - pop) : PW'(pop);
  end
  always_ff @(posedge Clk_In or negedge Resetb_In)
    if (!Resetb_In) begin
      Count_Out   <= RST_PAT;
      Wrap_Out    <= 1'b0;
      Illegal_Out <= 1'b0;
    end else begin
      Count_Out   <= nxt;
      Wrap_Out    <= wrap_n;
      Illegal_Out <= ill_n;
    end
endmodule

// File: tb/tb_johnson_counter_param.sv
// tb_johnson_counter_param: scoreboard bench for the self-correcting and flag-only counter variants
module tb_johnson_counter_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, rst_b, st_a, st_b, dr, ld_a, ld_b;
  logic [7:0] lv, cnt_a, cnt_b;
  logic [3:0] ph_a, ph_b;
  logic wr_a, wr_b, il_a, il_b;
  johnson_counter_param #(.WIDTH(8), .RESET_PHASE(0), .SELF_CORRECT(1)) dut_a (
    .Clk_In(clk), .Resetb_In(rst_a), .Start_Stopb_In(st_a), .Dir_In(dr), .Load_In(ld_a),
    .Load_Value_In(lv), .Count_Out(cnt_a), .Phase_Out(ph_a), .Wrap_Out(wr_a), .Illegal_Out(il_a));
  johnson_counter_param #(.WIDTH(8), .RESET_PHASE(0), .SELF_CORRECT(0)) dut_b (
    .Clk_In(clk), .Resetb_In(rst_b), .Start_Stopb_In(st_b), .Dir_In(dr), .Load_In(ld_b),
    .Load_Value_In(lv), .Count_Out(cnt_b), .Phase_Out(ph_b), .Wrap_Out(wr_b), .Illegal_Out(il_b));
  typedef struct {logic b; logic [7:0] c; logic [3:0] p; logic w; logic i;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0;
  logic [7:0] fwd_seq [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                               8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
  logic [7:0] rev_seq [6] = '{8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h80};
  logic [3:0] rev_ph  [6] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15};
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
    end
  endtask
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.b) begin
        check("b_count", 32'(cnt_b), 32'(e.c));
        check("b_wrap", 32'(wr_b), 32'(e.w));
        check("b_illegal", 32'(il_b), 32'(e.i));
      end else begin
        check("a_count", 32'(cnt_a), 32'(e.c));
        check("a_phase", 32'(ph_a), 32'(e.p));
        check("a_wrap", 32'(wr_a), 32'(e.w));
        check("a_illegal", 32'(il_a), 32'(e.i));
      end
    end
  end
  task automatic cyc(input logic b, input logic ld, input logic [7:0] v, input logic st, input logic d,
                     input logic [7:0] c, input logic [3:0] p, input logic w, input logic i);
    @(negedge clk);
    dr = d;
    lv = v;
    ld_a = b ? 1'b0 : ld;
    st_a = b ? 1'b0 : st;
    ld_b = b ? ld : 1'b0;
    st_b = b ? st : 1'b0;
    q.push_back('{b, c, p, w, i});
  endtask
  initial begin
    rst_a = 0; rst_b = 0; st_a = 0; st_b = 0; dr = 0; ld_a = 0; ld_b = 0; lv = '0;
    #3;
    check("reset_count", 32'(cnt_a), 32'h00);
    check("reset_phase", 32'(ph_a), 32'd0);
    check("reset_wrap", 32'(wr_a), 32'd0);
    check("reset_illegal", 32'(il_a), 32'd0);
    @(negedge clk);
    rst_a = 1;
    for (int k = 0; k < 16; k++) cyc(0, 0, 8'h00, 1, 0, fwd_seq[k], 4'((k + 1) % 16), k == 15, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 8'h00, 1, 0, fwd_seq[k], 4'(k + 1), 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 8'h00, 1, 1, rev_seq[k], rev_ph[k], k == 5, 0);
    cyc(0, 0, 8'h00, 1, 0, 8'h00, 4'd0, 1, 0);
    for (int k = 1; k < 10; k++) cyc(0, 0, 8'h00, 1, 0, fwd_seq[k-1], 4'(k), 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 8'h00, 0, 0, 8'hFE, 4'd9, 0, 0);
    cyc(0, 0, 8'h00, 1, 0, 8'hFC, 4'd10, 0, 0);
    cyc(0, 1, 8'h0F, 1, 1, 8'h0F, 4'd4, 0, 0);
    cyc(0, 0, 8'h00, 1, 1, 8'h07, 4'd3, 0, 0);
    cyc(0, 1, 8'hA5, 1, 0, 8'h00, 4'd0, 0, 1);
    cyc(0, 0, 8'h00, 0, 0, 8'h00, 4'd0, 0, 0);
    cyc(0, 0, 8'h00, 1, 1, 8'h80, 4'd15, 1, 0);
    cyc(0, 1, 8'h00, 1, 0, 8'h00, 4'd0, 0, 0);
    for (int k = 0; k < 12; k++) cyc(0, 0, 8'h00, 1, 0, fwd_seq[k], 4'(k + 1), 0, 0);
    @(posedge clk);
    #3 rst_a = 0;
    #1;
    check("async_count", 32'(cnt_a), 32'h00);
    check("async_phase", 32'(ph_a), 32'd0);
    check("async_wrap", 32'(wr_a), 32'd0);
    check("async_illegal", 32'(il_a), 32'd0);
    @(negedge clk);
    rst_a = 1;
    q.push_back('{1'b0, 8'h01, 4'd1, 1'b0, 1'b0});
    cyc(0, 0, 8'h00, 1, 0, 8'h03, 4'd2, 0, 0);
    @(negedge clk);
    rst_b = 1;
    cyc(1, 1, 8'hA5, 0, 0, 8'hA5, 4'd0, 0, 1);
    for (int k = 0; k < 3; k++) cyc(1, 0, 8'h00, 0, 0, 8'hA5, 4'd0, 0, 1);
    cyc(1, 0, 8'h00, 1, 0, 8'h4A, 4'd0, 0, 1);
    cyc(1, 1, 8'h07, 0, 0, 8'h07, 4'd0, 0, 0);
    cyc(1, 0, 8'h00, 0, 0, 8'h07, 4'd0, 0, 0);
    for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
    #5;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
